irq_priority_encoder: RTL

- Sequential 8-to-3 priority encoder for the CAP17 interrupt path. It is the inverse of the 3-to-8 decoder.
- It latches rising edges on 8 request lines into a pending register.
- It presents the index of the highest-priority unmasked pending request to the control unit with a valid/ack handshake.
- It counts requests that are lost because they arrive while the same line is already pending.

---
 rtl/irq_priority_encoder.sv | 109 ++++++++++
 1 files changed

// File: rtl/irq_priority_encoder.sv
// Sequential 8-to-3 interrupt priority encoder: latches request edges into a
// pending register and grants the lowest unmasked pending line via valid/ack.
module irq_priority_encoder #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [N-1:0]  encoder_in,
  input  logic [N-1:0]  mask,
  input  logic          ack,
  output logic [W-1:0]  encoder_out,
  output logic          valid,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] miss_count
);

  localparam int PW = $clog2(N + 1);
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

  state_t         state, state_next;
  logic [N-1:0]   prev_in;
  logic [N-1:0]   req_edge;
  logic [N-1:0]   clear_vec;
  logic [N-1:0]   pending_next;
  logic [N-1:0]   miss_vec;
  logic [N-1:0]   cand;
  logic [W-1:0]   index;
  logic [PW-1:0]  miss_num;
  logic [SW-1:0]  miss_sum;
  logic           grant_ack;
  logic           grant_start;

  // A new edge on a line wins over the ack clearing that same line.
  always_comb begin
    req_edge  = encoder_in & ~prev_in;
    grant_ack = (state == GRANT) && ack;
    clear_vec = '0;
    if (grant_ack) begin
      clear_vec[encoder_out] = 1'b1;
    end
    pending_next = req_edge | (pending & ~clear_vec);
    miss_vec     = req_edge & pending & ~clear_vec;
    cand         = pending & ~mask;
    grant_start  = (state == IDLE) && enable && (cand != '0);
  end

  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        index = W'(i);
      end
    end
  end

  always_comb begin
    miss_num = '0;
    for (int i = 0; i < N; i++) begin
      miss_num = miss_num + PW'(miss_vec[i]);
    end
    miss_sum = {1'b0, miss_count} + SW'(miss_num);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_start) state_next = GRANT;
      GRANT:   if (ack)         state_next = HOLDOFF;
      HOLDOFF:                  state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == GRANT);
  end

  // encoder_out is loaded only when a grant starts, so it stays frozen
  // through GRANT and keeps its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_in     <= '0;
      pending     <= '0;
      miss_count  <= '0;
      encoder_out <= '0;
    end else begin
      prev_in    <= encoder_in;
      pending    <= pending_next;
      miss_count <= miss_sum[CW] ? {CW{1'b1}} : miss_sum[CW-1:0];
      if (grant_start) begin
        encoder_out <= index;
      end
    end
  end

endmodule
